rank_pifo_feeder: RTL and testbench

// - Downstream neighbour of the strict rank stage: drains (rank, meta) entries from its fallthrough FIFO
//   and issues them into the PIFO insert port.
// - Adds a saturating rank offset and a 2-entry buffer so PIFO backpressure never forms a

---
 rtl/rank_pipe_pkg.sv | 21 ++
 rtl/rank_feeder_skid.sv | 48 ++++
 rtl/rank_pifo_feeder.sv | 89 ++++++++
 tb/tb_rank_pifo_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_pipe_pkg.sv
// Shared rank-pipeline constants and helpers used by the rank stages and the PIFO feeder.
package rank_pipe_pkg;

   localparam int unsigned DefRankWidth  = 16;
   localparam int unsigned DefMetaWidth  = 16;
   localparam int unsigned DefEntryWidth = DefRankWidth + DefMetaWidth;

   // Saturating add at 'width' bits (1..32); operands must already fit in 'width' bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [31:0] all_ones;
      sum      = {1'b0, a} + {1'b0, b};
      all_ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      if ((sum >> width) != 33'd0) begin
         return all_ones;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/rank_feeder_skid.sv
// Two-entry circular buffer with 1-bit head/tail pointers, occupancy count and synchronous flush.
module rank_feeder_skid
   import rank_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DefEntryWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/rank_pifo_feeder.sv
// Drains the rank stage's fallthrough head into the PIFO insert port through a 2-entry buffer.
// Define RANK_FEEDER_STATS_EN to build the pop/transfer/drop counters; otherwise stat_* read 0.
module rank_pifo_feeder
   import rank_pipe_pkg::*;
#(
   parameter int unsigned RANK_WIDTH  = DefRankWidth,
   parameter int unsigned META_WIDTH  = DefMetaWidth,
   parameter int unsigned RANK_OFFSET = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  up_valid,
   input  logic [RANK_WIDTH-1:0] up_rank,
   input  logic [META_WIDTH-1:0] up_meta,
   output logic                  up_remove,
   output logic                  pifo_insert,
   output logic [RANK_WIDTH-1:0] pifo_rank,
   output logic [META_WIDTH-1:0] pifo_meta,
   input  logic                  pifo_ready,
   input  logic                  flush,
   output logic [1:0]            occupancy,
   output logic [31:0]           stat_in_cnt,
   output logic [31:0]           stat_out_cnt,
   output logic [31:0]           stat_drop_cnt
);

   localparam int unsigned EntryWidth = RANK_WIDTH + META_WIDTH;

   logic [1:0]            count;
   logic [EntryWidth-1:0] head;
   logic [RANK_WIDTH-1:0] off_rank;
   logic                  transfer;

   // Pop depends only on registered count, so PIFO backpressure never reaches the rank stage.
   assign up_remove   = rst & up_valid & ~flush & (count < 2'd2);
   assign pifo_insert = (count != 2'd0) & ~flush;
   assign transfer    = pifo_insert & pifo_ready;
   assign off_rank    = RANK_WIDTH'(sat_add(32'(up_rank), 32'(RANK_OFFSET), RANK_WIDTH));

   rank_feeder_skid #(
      .WIDTH(EntryWidth)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (up_remove),
      .push_data({off_rank, up_meta}),
      .pop      (transfer),
      .flush    (flush),
      .count    (count),
      .head_data(head)
   );

   assign pifo_rank = head[EntryWidth-1 -: RANK_WIDTH];
   assign pifo_meta = head[META_WIDTH-1:0];
   assign occupancy = count;

`ifdef RANK_FEEDER_STATS_EN
   logic [31:0] in_cnt_q;
   logic [31:0] out_cnt_q;
   logic [31:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cnt_q   <= 32'd0;
         out_cnt_q  <= 32'd0;
         drop_cnt_q <= 32'd0;
      end else begin
         if (up_remove) begin
            in_cnt_q <= in_cnt_q + 32'd1;
         end
         if (transfer) begin
            out_cnt_q <= out_cnt_q + 32'd1;
         end
         if (flush) begin
            drop_cnt_q <= drop_cnt_q + 32'(count);
         end
      end
   end

   assign stat_in_cnt   = in_cnt_q;
   assign stat_out_cnt  = out_cnt_q;
   assign stat_drop_cnt = drop_cnt_q;
`else
   assign stat_in_cnt   = 32'd0;
   assign stat_out_cnt  = 32'd0;
   assign stat_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rank_pifo_feeder.sv
// Bench for rank_pifo_feeder: two instances (offset 0 and 16) against a queue model plus literals.
module tb_rank_pifo_feeder;

   logic        clk;
   logic        rst;
   logic        up_valid;
   logic [15:0] up_rank;
   logic [15:0] up_meta;
   logic        pifo_ready;
   logic        flush;

   logic        a_up_remove, a_pifo_insert;
   logic [15:0] a_pifo_rank, a_pifo_meta;
   logic [1:0]  a_occupancy;
   logic [31:0] a_si, a_so, a_sd;

   logic        b_up_remove, b_pifo_insert;
   logic [15:0] b_pifo_rank, b_pifo_meta;
   logic [1:0]  b_occupancy;
   logic [31:0] b_si, b_so, b_sd;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] up_q[$];   // emulated upstream FIFO, {rank, meta}
   logic [31:0] mq[$];     // model: raw upstream words held by the feeder
   int unsigned in_cnt, out_cnt, drop_cnt;
   logic        rem_seen = 1'b0;

   rank_pifo_feeder #(.RANK_WIDTH(16), .META_WIDTH(16), .RANK_OFFSET(0)) dut_a (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_rank(up_rank), .up_meta(up_meta),
      .up_remove(a_up_remove), .pifo_insert(a_pifo_insert), .pifo_rank(a_pifo_rank),
      .pifo_meta(a_pifo_meta), .pifo_ready(pifo_ready), .flush(flush),
      .occupancy(a_occupancy), .stat_in_cnt(a_si), .stat_out_cnt(a_so), .stat_drop_cnt(a_sd)
   );

   rank_pifo_feeder #(.RANK_WIDTH(16), .META_WIDTH(16), .RANK_OFFSET(16)) dut_b (
      .clk(clk), .rst(rst), .up_valid(up_valid), .up_rank(up_rank), .up_meta(up_meta),
      .up_remove(b_up_remove), .pifo_insert(b_pifo_insert), .pifo_rank(b_pifo_rank),
      .pifo_meta(b_pifo_meta), .pifo_ready(pifo_ready), .flush(flush),
      .occupancy(b_occupancy), .stat_in_cnt(b_si), .stat_out_cnt(b_so), .stat_drop_cnt(b_sd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] sat(input logic [15:0] r, input int unsigned off);
      int unsigned s;
      s = int'(r) + off;
      if (s > 65535) return 16'hFFFF;
      return s[15:0];
   endfunction

   task automatic check_dut(input string tag, input int unsigned off, input logic rem,
                            input logic ins, input logic [15:0] rk, input logic [15:0] mt,
                            input logic [1:0] occ, input logic [31:0] si, input logic [31:0] so,
                            input logic [31:0] sd);
      logic e_ins, e_rem;
      logic [31:0] e_si, e_so, e_sd;
      e_ins = rst && !flush && mq.size() != 0;
      e_rem = rst && up_valid && !flush && mq.size() < 2;
      chk({tag, ".up_remove"}, 32'(rem), 32'(e_rem));
      chk({tag, ".pifo_insert"}, 32'(ins), 32'(e_ins));
      chk({tag, ".occupancy"}, 32'(occ), mq.size());
      if (e_ins) begin
         chk({tag, ".pifo_rank"}, 32'(rk), 32'(sat(mq[0][31:16], off)));
         chk({tag, ".pifo_meta"}, 32'(mt), 32'(mq[0][15:0]));
      end else if (!rst) begin
         chk({tag, ".rank_rst"}, 32'(rk), 32'd0);
         chk({tag, ".meta_rst"}, 32'(mt), 32'd0);
      end
`ifdef RANK_FEEDER_STATS_EN
      e_si = in_cnt; e_so = out_cnt; e_sd = drop_cnt;
`else
      e_si = 0; e_so = 0; e_sd = 0;
`endif
      chk({tag, ".stat_in"}, si, e_si);
      chk({tag, ".stat_out"}, so, e_so);
      chk({tag, ".stat_drop"}, sd, e_sd);
   endtask

   // Compare on the falling edge, then advance the model to what the next rising edge does.
   initial begin
      logic e_ins, e_rem;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mq.delete();
            in_cnt = 0; out_cnt = 0; drop_cnt = 0;
         end
         check_dut("a", 0, a_up_remove, a_pifo_insert, a_pifo_rank, a_pifo_meta, a_occupancy,
                   a_si, a_so, a_sd);
         check_dut("b", 16, b_up_remove, b_pifo_insert, b_pifo_rank, b_pifo_meta, b_occupancy,
                   b_si, b_so, b_sd);
         rem_seen = a_up_remove;
         if (rst) begin
            if (flush) begin
               drop_cnt += mq.size();
               mq.delete();
            end else begin
               e_ins = mq.size() != 0;
               e_rem = up_valid && mq.size() < 2;
               if (e_ins && pifo_ready) begin
                  void'(mq.pop_front());
                  out_cnt++;
               end
               if (e_rem) begin
                  mq.push_back({up_rank, up_meta});
                  in_cnt++;
               end
            end
         end
      end
   end

   task automatic drive_up();
      up_valid = up_q.size() != 0;
      if (up_valid) {up_rank, up_meta} = up_q[0];
      else {up_rank, up_meta} = 32'd0;
   endtask

   task automatic tick(input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      if (rem_seen) void'(up_q.pop_front());
      pifo_ready = rdy;
      flush      = fl;
      drive_up();
      #1;
   endtask

   initial begin
      int pops, ins, occ_bad;
      logic [15:0] first_meta;
      logic found;
      rst = 1'b1; pifo_ready = 1'b0; flush = 1'b0;
      up_q.push_back({16'd5, 16'hA});
      drive_up();
      #1 rst = 1'b0;
      repeat (3) tick(1, 0);
      chk("reset_insert", 32'(a_pifo_insert), 32'd0);
      chk("reset_remove", 32'(a_up_remove), 32'd0);
      chk("reset_occ", 32'(a_occupancy), 32'd0);

      // Test 1: one-cycle latency
      tick(1, 0);
      rst = 1'b1;
      #1;
      chk("t1_remove_c0", 32'(a_up_remove), 32'd1);
      chk("t1_insert_c0", 32'(a_pifo_insert), 32'd0);
      tick(1, 0);
      chk("t1_insert_c1", 32'(a_pifo_insert), 32'd1);
      chk("t1_rank_c1", 32'(a_pifo_rank), 32'd5);
      chk("t1_meta_c1", 32'(a_pifo_meta), 32'hA);
      chk("t1_rank_off16", 32'(b_pifo_rank), 32'h15);
      tick(1, 0);
      tick(1, 0);

      // Test 2: offset saturation
      up_q.push_back({16'hFFF5, 16'h11});
      up_q.push_back({16'h0010, 16'h22});
      drive_up();
      tick(1, 0);
      chk("t2_sat_b", 32'(b_pifo_rank), 32'hFFFF);
      chk("t2_nosat_a", 32'(a_pifo_rank), 32'hFFF5);
      tick(1, 0);
      chk("t2_add_b", 32'(b_pifo_rank), 32'h0020);
      chk("t2_meta", 32'(b_pifo_meta), 32'h22);
      tick(1, 0);
      tick(1, 0);

      // Test 3: backpressure, then in-order drain
      pifo_ready = 1'b0;
      for (int i = 0; i < 3; i++) up_q.push_back({16'(100 + i), 16'(16'h31 + i)});
      drive_up();
      #1;
      pops = 0;
      for (int i = 0; i < 5; i++) begin
         pops += int'(a_up_remove);
         tick(0, 0);
      end
      chk("t3_pops", pops, 2);
      chk("t3_occ", 32'(a_occupancy), 32'd2);
      chk("t3_remove_full", 32'(a_up_remove), 32'd0);
      pifo_ready = 1'b1;
      #1;
      chk("t3_out0", 32'(a_pifo_meta), 32'h31);
      tick(1, 0);
      chk("t3_out1", 32'(a_pifo_meta), 32'h32);
      chk("t3_resume_pop", 32'(a_up_remove), 32'd1);
      tick(1, 0);
      chk("t3_out2", 32'(a_pifo_meta), 32'h33);
      chk("t3_out2_ins", 32'(a_pifo_insert), 32'd1);
      tick(1, 0);
      chk("t3_empty", 32'(a_pifo_insert), 32'd0);

      // Test 4: sustained throughput
      for (int i = 0; i < 100; i++) up_q.push_back({16'(i * 7), 16'(i)});
      drive_up();
      #1;
      pops = 0; ins = 0; occ_bad = 0;
      for (int i = 0; i < 100; i++) begin
         pops += int'(a_up_remove);
         if (i > 0) begin
            ins += int'(a_pifo_insert);
            if (a_occupancy != 2'd1) occ_bad++;
         end
         tick(1, 0);
      end
      chk("t4_pops", pops, 100);
      chk("t4_inserts", ins, 99);
      chk("t4_occ_not1", occ_bad, 0);
      tick(1, 0);

      // Test 5: flush with two buffered
      pifo_ready = 1'b0;
      for (int i = 0; i < 3; i++) up_q.push_back({16'(200 + i), 16'(16'h41 + i)});
      drive_up();
      tick(0, 0);
      tick(0, 0);
      chk("t5_occ2", 32'(a_occupancy), 32'd2);
      flush = 1'b1;
      #1;
      chk("t5_flush_ins", 32'(a_pifo_insert), 32'd0);
      chk("t5_flush_rem", 32'(a_up_remove), 32'd0);
      tick(0, 0);
      chk("t5_occ0", 32'(a_occupancy), 32'd0);
`ifdef RANK_FEEDER_STATS_EN
      chk("t5_drop", a_sd, 32'd2);
`endif
      repeat (3) tick(1, 0);

      // Test 6: asynchronous reset mid-burst
      for (int i = 0; i < 6; i++) up_q.push_back({16'(300 + i), 16'(51 + i)});
      drive_up();
      repeat (3) tick(1, 0);
      #1 rst = 1'b0;
      #1;
      chk("t6_ins_async", 32'(a_pifo_insert), 32'd0);
      chk("t6_occ_async", 32'(a_occupancy), 32'd0);
      chk("t6_rank_async", 32'(a_pifo_rank), 32'd0);
      chk("t6_rem_async", 32'(a_up_remove), 32'd0);
      tick(1, 0);
      tick(1, 0);
      rst = 1'b1;
      found = 1'b0;
      first_meta = 16'd0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick(1, 0);
         if (a_pifo_insert && pifo_ready) begin
            found = 1'b1;
            first_meta = a_pifo_meta;
         end
      end
      chk("t6_first_found", 32'(found), 32'd1);
      chk("t6_first_meta", 32'(first_meta), 32'd54);
      repeat (6) tick(1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
